// File: rtl/param_accumulator.sv
// param_accumulator: NUM_ACC independent WIDTH-bit accumulator banks with one registered result stage
//
// Ports
//   CLK        in   clock, rising edge
//   reset      in   asynchronous, active-low reset
//   IOIn       in   operand
//   op         in   000 NOP/read, 001 LOAD, 010 ADD, 011 SUB, 100 CLEAR, 101 CLEAR_ALL, 11x NOP
//   sel        in   target bank; values >= NUM_ACC act as NOP and read back 0
//   in_valid   in   op/IOIn/sel valid
//   in_ready   out  block can accept this cycle
//   Output     out  post-operation value of the selected bank
//   out_sel    out  bank that Output belongs to
//   out_ovf    out  sticky overflow flag of that bank
//   out_valid  out  result held
//   out_ready  in   consumer accepts result
module param_accumulator #(
   parameter int WIDTH   = 16,
   parameter int NUM_ACC = 4,
   parameter bit SAT_EN  = 1,
   parameter bit SIGNED  = 0,
   localparam int SEL_W  = $clog2(NUM_ACC)
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic [WIDTH-1:0] IOIn,
   input  logic [2:0]       op,
   input  logic [SEL_W-1:0] sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] Output,
   output logic [SEL_W-1:0] out_sel,
   output logic             out_ovf,
   output logic             out_valid,
   input  logic             out_ready
);
   localparam logic [2:0] OP_LOAD = 3'b001, OP_ADD = 3'b010, OP_SUB = 3'b011;
   localparam logic [2:0] OP_CLEAR = 3'b100, OP_CLEAR_ALL = 3'b101;
   localparam logic [WIDTH-1:0] UMAX = '1;
   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
   typedef enum logic {EMPTY, FULL} state_t;
   state_t state_q, state_d;
   logic [NUM_ACC-1:0][WIDTH-1:0] bank;
   logic [NUM_ACC-1:0] ovf;
   logic accept, sel_ok, wr, clr_all, add_ovf, sub_ovf, cur_ovf, nxt_ovf;
   logic [WIDTH-1:0] cur, nxt_val, sat_val;
   logic [WIDTH:0] sum, diff;
   assign out_valid = state_q == FULL;
   assign in_ready  = !out_valid | out_ready;
   assign accept    = in_valid & in_ready;
   // widened compare so the test stays meaningful when NUM_ACC is a power of two
   assign sel_ok    = {1'b0, sel} < (SEL_W+1)'(NUM_ACC);
   assign cur       = sel_ok ? bank[sel] : '0;
   assign cur_ovf   = sel_ok & ovf[sel];
   assign sum       = {1'b0, cur} + {1'b0, IOIn};
   assign diff      = {1'b0, cur} - {1'b0, IOIn};
   // signed: overflow only when the result sign departs from the bank sign with compatible operand signs
   assign add_ovf   = SIGNED ? (cur[WIDTH-1] == IOIn[WIDTH-1]) & (sum[WIDTH-1] != cur[WIDTH-1]) : sum[WIDTH];
   assign sub_ovf   = SIGNED ? (cur[WIDTH-1] != IOIn[WIDTH-1]) & (diff[WIDTH-1] != cur[WIDTH-1]) : diff[WIDTH];
   // signed overflow always runs away from zero in the direction of the bank's own sign
   assign sat_val   = SIGNED ? (cur[WIDTH-1] ? SMIN : SMAX) : (op == OP_ADD ? UMAX : '0);
   assign wr        = accept & sel_ok & (op inside {OP_LOAD, OP_ADD, OP_SUB, OP_CLEAR});
   assign clr_all   = accept & sel_ok & (op == OP_CLEAR_ALL);
   always_comb begin
      nxt_val = cur;
      nxt_ovf = cur_ovf;
      case (op)
         OP_LOAD: begin
            nxt_val = IOIn;
            nxt_ovf = 1'b0;
         end
         OP_ADD: begin
            nxt_val = (add_ovf && SAT_EN) ? sat_val : sum[WIDTH-1:0];
            nxt_ovf = cur_ovf | add_ovf;
         end
         OP_SUB: begin
            nxt_val = (sub_ovf && SAT_EN) ? sat_val : diff[WIDTH-1:0];
            nxt_ovf = cur_ovf | sub_ovf;
         end
         OP_CLEAR, OP_CLEAR_ALL: begin
            nxt_val = '0;
            nxt_ovf = 1'b0;
         end
         default: ;
      endcase
   end
   always_comb state_d = accept ? FULL : (out_ready ? EMPTY : state_q);
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) state_q <= EMPTY;
      else        state_q <= state_d;
   end
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         bank    <= '0;
         ovf     <= '0;
         Output  <= '0;
         out_sel <= '0;
         out_ovf <= 1'b0;
      end else begin
         if (clr_all) begin
            bank <= '0;
            ovf  <= '0;
         end else if (wr) begin
            bank[sel] <= nxt_val;
            ovf[sel]  <= nxt_ovf;
         end
         if (accept) begin
            Output  <= sel_ok ? nxt_val : '0;
            out_sel <= sel;
            out_ovf <= sel_ok & nxt_ovf;
         end
      end
   end
endmodule

// File: tb/tb_param_accumulator.sv
// tb_param_accumulator: three accumulator configurations driven in lockstep against an arithmetic model
module tb_param_accumulator;
   logic CLK = 0, reset = 1, in_valid = 0, out_ready = 1;
   logic [15:0] IOIn = 0;
   logic [2:0] op = 0;
   logic [1:0] sel = 0;
   logic [15:0] dout [3];
   logic [1:0] dsel [3];
   logic dovf [3], dvalid [3], drdy [3];
   int n_cmp = 0, n_fail = 0;
   bit go = 0;
   always #5 CLK = ~CLK;
   // dut 0: saturating unsigned, dut 1: wrapping unsigned, dut 2: saturating signed
   param_accumulator #(.WIDTH(16), .NUM_ACC(4), .SAT_EN(1), .SIGNED(0)) u_us (
      .CLK(CLK), .reset(reset), .IOIn(IOIn), .op(op), .sel(sel), .in_valid(in_valid), .in_ready(drdy[0]),
      .Output(dout[0]), .out_sel(dsel[0]), .out_ovf(dovf[0]), .out_valid(dvalid[0]), .out_ready(out_ready));
   param_accumulator #(.WIDTH(16), .NUM_ACC(4), .SAT_EN(0), .SIGNED(0)) u_uw (
      .CLK(CLK), .reset(reset), .IOIn(IOIn), .op(op), .sel(sel), .in_valid(in_valid), .in_ready(drdy[1]),
      .Output(dout[1]), .out_sel(dsel[1]), .out_ovf(dovf[1]), .out_valid(dvalid[1]), .out_ready(out_ready));
   param_accumulator #(.WIDTH(16), .NUM_ACC(4), .SAT_EN(1), .SIGNED(1)) u_ss (
      .CLK(CLK), .reset(reset), .IOIn(IOIn), .op(op), .sel(sel), .in_valid(in_valid), .in_ready(drdy[2]),
      .Output(dout[2]), .out_sel(dsel[2]), .out_ovf(dovf[2]), .out_valid(dvalid[2]), .out_ready(out_ready));
   logic [15:0] mb [3][4];
   bit mo [3][4];
   bit exp_valid = 0;
   logic [15:0] exp_out [3];
   bit exp_ovf [3];
   logic [1:0] exp_sel = 0;
   task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d t=%0t got %h want %h", nm, c, $time, act, exp);
      end
   endtask
   task automatic model_clear();
      for (int c = 0; c < 3; c++) begin
         for (int b = 0; b < 4; b++) begin
            mb[c][b] = 0;
            mo[c][b] = 0;
         end
         exp_out[c] = 0;
         exp_ovf[c] = 0;
      end
      exp_valid = 0;
      exp_sel = 0;
   endtask
   task automatic model_op(input int c);
      bit sat, sgn;
      int a, b, t, lo, hi;
      sat = c != 1;
      sgn = c == 2;
      a = sgn ? int'($signed(mb[c][sel])) : int'(mb[c][sel]);
      b = sgn ? int'($signed(IOIn)) : int'(IOIn);
      lo = sgn ? -32768 : 0;
      hi = sgn ? 32767 : 65535;
      if (op == 3'd1) begin
         mb[c][sel] = IOIn;
         mo[c][sel] = 0;
      end else if (op == 3'd2 || op == 3'd3) begin
         t = (op == 3'd2) ? a + b : a - b;
         if (t > hi || t < lo) begin
            mo[c][sel] = 1;
            if (sat) t = (t > hi) ? hi : lo;
         end
         mb[c][sel] = 16'(t);
      end else if (op == 3'd4) begin
         mb[c][sel] = 0;
         mo[c][sel] = 0;
      end else if (op == 3'd5) begin
         for (int k = 0; k < 4; k++) begin
            mb[c][k] = 0;
            mo[c][k] = 0;
         end
      end
      exp_out[c] = mb[c][sel];
      exp_ovf[c] = mo[c][sel];
   endtask
   initial model_clear();
   always @(posedge CLK or negedge reset) begin
      if (!reset) model_clear();
      else if (in_valid && (!exp_valid || out_ready)) begin
         for (int c = 0; c < 3; c++) model_op(c);
         exp_sel = sel;
         exp_valid = 1;
      end else if (out_ready) exp_valid = 0;
   end
   always @(negedge CLK) if (go) begin
      for (int c = 0; c < 3; c++) begin
         chk("out_valid", c, 32'(dvalid[c]), 32'(exp_valid));
         chk("in_ready", c, 32'(drdy[c]), 32'(!exp_valid || out_ready));
         if (exp_valid) begin
            chk("Output", c, 32'(dout[c]), 32'(exp_out[c]));
            chk("out_sel", c, 32'(dsel[c]), 32'(exp_sel));
            chk("out_ovf", c, 32'(dovf[c]), 32'(exp_ovf[c]));
         end
      end
   end
   task automatic xact(input logic [2:0] o, input logic [1:0] s, input logic [15:0] d);
      op = o;
      sel = s;
      IOIn = d;
      in_valid = 1;
      @(posedge CLK);
      #2;
      in_valid = 0;
   endtask
   task automatic lit(input string nm, input logic [15:0] e0, e1, e2, input bit v0, v1, v2);
      chk({nm, "_val"}, 0, 32'(dout[0]), 32'(e0));
      chk({nm, "_val"}, 1, 32'(dout[1]), 32'(e1));
      chk({nm, "_val"}, 2, 32'(dout[2]), 32'(e2));
      chk({nm, "_ovf"}, 0, 32'(dovf[0]), 32'(v0));
      chk({nm, "_ovf"}, 1, 32'(dovf[1]), 32'(v1));
      chk({nm, "_ovf"}, 2, 32'(dovf[2]), 32'(v2));
   endtask
   initial begin
      #1 reset = 0;
      go = 1;
      repeat (3) @(posedge CLK);
      #2;
      for (int c = 0; c < 3; c++) begin
         chk("rst_valid", c, 32'(dvalid[c]), 0);
         chk("rst_out", c, 32'(dout[c]), 0);
         chk("rst_ready", c, 32'(drdy[c]), 1);
      end
      reset = 1;
      @(posedge CLK);
      #2;
      for (int b = 0; b < 4; b++) begin
         xact(3'd0, 2'(b), 16'h5a5a);
         lit("read", 0, 0, 0, 0, 0, 0);
         chk("read_valid", 0, 32'(dvalid[0]), 1);
         chk("read_sel", 0, 32'(dsel[0]), b);
      end
      xact(3'd1, 0, 16'hff00);
      lit("load_ff00", 16'hff00, 16'hff00, 16'hff00, 0, 0, 0);
      xact(3'd2, 0, 16'h0100);
      lit("add_over", 16'hffff, 16'h0000, 16'h0000, 1, 1, 0);
      xact(3'd1, 0, 16'h0005);
      lit("reload", 16'h0005, 16'h0005, 16'h0005, 0, 0, 0);
      xact(3'd3, 0, 16'h0009);
      lit("sub_under", 16'h0000, 16'hfffc, 16'hfffc, 1, 1, 0);
      xact(3'd4, 0, 0);
      for (int i = 1; i <= 3; i++) begin
         xact(3'd2, 0, 16'h0001);
         lit("inc", 16'(i), 16'(i), 16'(i), 0, 0, 0);
      end
      xact(3'd5, 0, 0);
      lit("clear_all", 0, 0, 0, 0, 0, 0);
      xact(3'd1, 1, 16'h7ff0);
      xact(3'd2, 1, 16'h0020);
      lit("s_add_max", 16'h8010, 16'h8010, 16'h7fff, 0, 0, 1);
      xact(3'd1, 2, 16'h8010);
      xact(3'd3, 2, 16'h0020);
      lit("s_sub_min", 16'h7ff0, 16'h7ff0, 16'h8000, 0, 0, 1);
      xact(3'd0, 0, 0);
      lit("b0_zero", 0, 0, 0, 0, 0, 0);
      xact(3'd0, 3, 0);
      lit("b3_zero", 0, 0, 0, 0, 0, 0);
      xact(3'd1, 3, 16'h1234);
      out_ready = 0;
      op = 3'd2;
      sel = 3;
      IOIn = 16'h0001;
      in_valid = 1;
      repeat (4) begin
         @(posedge CLK);
         #2;
         chk("bp_ready", 0, 32'(drdy[0]), 0);
         lit("bp_hold", 16'h1234, 16'h1234, 16'h1234, 0, 0, 0);
      end
      out_ready = 1;
      @(posedge CLK);
      #2;
      in_valid = 0;
      lit("bp_release", 16'h1235, 16'h1235, 16'h1235, 0, 0, 0);
      xact(3'd1, 0, 16'habcd);
      #1 reset = 0;
      #1;
      for (int c = 0; c < 3; c++) begin
         chk("async_valid", c, 32'(dvalid[c]), 0);
         chk("async_out", c, 32'(dout[c]), 0);
      end
      repeat (2) @(posedge CLK);
      #2 reset = 1;
      chk("post_rst_ready", 0, 32'(drdy[0]), 1);
      @(posedge CLK);
      #2;
      xact(3'd5, 0, 0);
      lit("post_rst_clr", 0, 0, 0, 0, 0, 0);
      xact(3'd0, 1, 0);
      lit("post_rst_b1", 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 2000; i++) begin
         int k;
         k = int'($urandom_range(0, 3));
         in_valid = $urandom_range(0, 3) != 0;
         out_ready = $urandom_range(0, 9) < 7;
         op = 3'($urandom_range(0, 7));
         sel = 2'($urandom);
         IOIn = k == 0 ? 16'($urandom) : k == 1 ? 16'hfff0 + 16'($urandom_range(0, 15)) :
                k == 2 ? 16'h7ff0 + 16'($urandom_range(0, 31)) : 16'($urandom_range(0, 64));
         if (i == 1000) begin
            #1 reset = 0;
            #3 reset = 1;
         end
         @(posedge CLK);
         #2;
      end
      in_valid = 0;
      out_ready = 1;
      repeat (3) @(posedge CLK);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
